// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file / PC context stack.
// Optional feature macro: REGFILE_BYPASS_EN (write-through read forwarding).
package regfile_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int NUM_REGS_DEF  = 8;
    localparam int PC_W_DEF      = 32;
    localparam int CTX_DEPTH_DEF = 4;

    localparam int REG_AW = $clog2(NUM_REGS_DEF);
    localparam int CTX_CW = $clog2(CTX_DEPTH_DEF + 1);

    typedef enum logic [1:0] {
        CTX_EMPTY,
        CTX_PARTIAL,
        CTX_FULL
    } ctx_state_e;

endpackage

// File: rtl/regfile_ctx_if.sv
// Decode/write-back side bundle of the register file and context stack.
// Optional feature macro: REGFILE_BYPASS_EN (no effect on this bundle).
interface regfile_ctx_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int PC_W     = PC_W_DEF
);
    localparam int AW = $clog2(NUM_REGS);

    logic              we;
    logic [AW-1:0]     waddr;
    logic [DATA_W-1:0] wdata;
    logic [AW-1:0]     raddr1;
    logic [AW-1:0]     raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              ctx_push;
    logic              ctx_pop;
    logic [PC_W-1:0]   pc_in;
    logic [PC_W-1:0]   pc_out;
    logic              pc_valid;
    logic              ctx_full;
    logic              ctx_empty;
    logic              ctx_err;

    modport master (
        output we, waddr, wdata, raddr1, raddr2,
        output ctx_push, ctx_pop, pc_in,
        input  rdata1, rdata2, pc_out, pc_valid,
        input  ctx_full, ctx_empty, ctx_err
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2,
        input  ctx_push, ctx_pop, pc_in,
        output rdata1, rdata2, pc_out, pc_valid,
        output ctx_full, ctx_empty, ctx_err
    );

endinterface

// File: rtl/pc_ctx_stack.sv
// LIFO of saved PC contexts with swap, pass-through and sticky error.
// Optional feature macro: REGFILE_BYPASS_EN (no effect on this block).
module pc_ctx_stack
    import regfile_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int CTX_DEPTH = CTX_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] pc_i,
    output logic [PC_W-1:0] pc_o,
    output logic            valid_o,
    output logic            full_o,
    output logic            empty_o,
    output logic            err_o
);
    localparam int CW = $clog2(CTX_DEPTH + 1);
    localparam int IW = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(CTX_DEPTH);

    logic [PC_W-1:0] mem_q [CTX_DEPTH];
    logic [CW-1:0]   count_q, count_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            wr_en;
    logic [IW-1:0]   wr_idx;
    logic [PC_W-1:0] wr_data;
    logic [CW-1:0]   top_c;
    logic [IW-1:0]   top_idx;
    logic [IW-1:0]   nxt_idx;
    ctx_state_e      state;

    assign top_c   = count_q - CW'(1);
    assign top_idx = top_c[IW-1:0];
    assign nxt_idx = count_q[IW-1:0];

    // Controller state is a pure decode of the occupancy count.
    always_comb begin
        state = CTX_PARTIAL;
        if (count_q == '0)
            state = CTX_EMPTY;
        else if (count_q == DEPTH_C)
            state = CTX_FULL;
    end

    // Next-state: push, pop, swap, pass-through and error rules.
    always_comb begin
        count_d = count_q;
        pc_d    = pc_q;
        valid_d = 1'b0;
        err_d   = err_q;
        wr_en   = 1'b0;
        wr_idx  = nxt_idx;
        wr_data = pc_i;
        case ({push_i, pop_i})
            2'b11: begin
                valid_d = 1'b1;
                if (state == CTX_EMPTY) begin
                    pc_d = pc_i;
                end else begin
                    pc_d   = mem_q[top_idx];
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                end
            end
            2'b10: begin
                if (state == CTX_FULL) begin
                    err_d = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            2'b01: begin
                if (state == CTX_EMPTY) begin
                    err_d = 1'b1;
                end else begin
                    pc_d    = mem_q[top_idx];
                    valid_d = 1'b1;
                    count_d = top_c;
                end
            end
            default: ;
        endcase
    end

    // Control registers; reset drops any in-flight push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Context storage, written at the push slot or the top on swap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CTX_DEPTH; i++)
                mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign pc_o    = pc_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign full_o  = (state == CTX_FULL);
    assign empty_o = (state == CTX_EMPTY);

endmodule

// File: rtl/regfile_ctx.sv
// General-purpose register file with a hardware PC context stack.
// Optional feature macro: REGFILE_BYPASS_EN (write-through read forwarding).
module regfile_ctx
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_REGS  = NUM_REGS_DEF,
    parameter int PC_W      = PC_W_DEF,
    parameter int CTX_DEPTH = CTX_DEPTH_DEF
) (
    input logic         clk,
    input logic         rst,
    regfile_ctx_if.slave bus
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Register array write port, one-cycle latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
        end else if (bus.we) begin
            regs_q[bus.waddr] <= bus.wdata;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Read muxes forward same-cycle write data on address match.
    always_comb begin
        bus.rdata1 = regs_q[bus.raddr1];
        bus.rdata2 = regs_q[bus.raddr2];
        if (bus.we && (bus.waddr == bus.raddr1))
            bus.rdata1 = bus.wdata;
        if (bus.we && (bus.waddr == bus.raddr2))
            bus.rdata2 = bus.wdata;
    end
`else
    // Read muxes return the stored value; writes show next cycle.
    always_comb begin
        bus.rdata1 = regs_q[bus.raddr1];
        bus.rdata2 = regs_q[bus.raddr2];
    end
`endif

    pc_ctx_stack #(
        .PC_W      (PC_W),
        .CTX_DEPTH (CTX_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.ctx_push),
        .pop_i   (bus.ctx_pop),
        .pc_i    (bus.pc_in),
        .pc_o    (bus.pc_out),
        .valid_o (bus.pc_valid),
        .full_o  (bus.ctx_full),
        .empty_o (bus.ctx_empty),
        .err_o   (bus.ctx_err)
    );

endmodule

// File: tb/tb_regfile_ctx.sv
// Self-checking bench for regfile_ctx with a PC scoreboard queue.
// Optional feature macro: REGFILE_BYPASS_EN (selects read expectation).
module tb_regfile_ctx;
    import regfile_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0] mstk  [$];
    logic [31:0] exp_q [$];
    bit          merr;

    regfile_ctx_if #(.DATA_W(16), .NUM_REGS(8), .PC_W(32)) bus ();

    regfile_ctx #(
        .DATA_W    (16),
        .NUM_REGS  (8),
        .PC_W      (32),
        .CTX_DEPTH (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.we       = 1'b0;
        bus.waddr    = '0;
        bus.wdata    = '0;
        bus.raddr1   = '0;
        bus.raddr2   = '0;
        bus.ctx_push = 1'b0;
        bus.ctx_pop  = 1'b0;
        bus.pc_in    = '0;
    endtask

    task automatic apply_reset();
        idle();
        rst = 1'b0;
        #3;
        rst = 1'b1;
        mstk.delete();
        exp_q.delete();
        merr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Drive one stack cycle; the model pushes expected pops to exp_q.
    task automatic cyc(input logic pu, input logic po, input logic [31:0] pci);
        logic [31:0] v;
        bus.ctx_push = pu;
        bus.ctx_pop  = po;
        bus.pc_in    = pci;
        if (pu && po) begin
            if (mstk.size() > 0) begin
                v = mstk[mstk.size()-1];
                mstk[mstk.size()-1] = pci;
                exp_q.push_back(v);
            end else begin
                exp_q.push_back(pci);
            end
        end else if (pu) begin
            if (mstk.size() < 4) mstk.push_back(pci);
            else merr = 1'b1;
        end else if (po) begin
            if (mstk.size() > 0) exp_q.push_back(mstk.pop_back());
            else merr = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.ctx_push = 1'b0;
        bus.ctx_pop  = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            bus.raddr1 = 3'(i);
            bus.raddr2 = 3'(7 - i);
            #1;
            total++;
            if (bus.rdata1 !== 16'h0 || bus.rdata2 !== 16'h0) begin
                bad++;
                $display("FAIL reset_regs[%0d] got=%h/%h exp=0", i, bus.rdata1, bus.rdata2);
            end
        end
        total++;
        if (bus.pc_out !== 32'h0 || bus.pc_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_pc got=%h/%b exp=0/0", bus.pc_out, bus.pc_valid);
        end
        total++;
        if (bus.ctx_full !== 1'b0 || bus.ctx_empty !== 1'b1 || bus.ctx_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got=f%b e%b r%b exp=f0 e1 r0",
                     bus.ctx_full, bus.ctx_empty, bus.ctx_err);
        end
    endtask

    task automatic test_write_read();
        bus.we    = 1'b1;
        bus.waddr = 3'd3;
        bus.wdata = 16'hBEEF;
        @(posedge clk);
        #1;
        bus.we     = 1'b0;
        bus.raddr1 = 3'd3;
        #1;
        total++;
        if (bus.rdata1 !== 16'hBEEF) begin
            bad++;
            $display("FAIL wr_rd3 got=%h exp=beef", bus.rdata1);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 3) continue;
            bus.raddr1 = 3'(i);
            bus.raddr2 = 3'(i);
            #1;
            total++;
            if (bus.rdata1 !== 16'h0 || bus.rdata2 !== 16'h0) begin
                bad++;
                $display("FAIL wr_other[%0d] got=%h/%h exp=0", i, bus.rdata1, bus.rdata2);
            end
        end
    endtask

    task automatic test_bypass();
        logic [15:0] same;
`ifdef REGFILE_BYPASS_EN
        same = 16'h1234;
`else
        same = 16'h0000;
`endif
        bus.we     = 1'b1;
        bus.waddr  = 3'd5;
        bus.wdata  = 16'h1234;
        bus.raddr2 = 3'd5;
        #1;
        total++;
        if (bus.rdata2 !== same) begin
            bad++;
            $display("FAIL bypass_same got=%h exp=%h", bus.rdata2, same);
        end
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        #1;
        total++;
        if (bus.rdata2 !== 16'h1234) begin
            bad++;
            $display("FAIL bypass_next got=%h exp=1234", bus.rdata2);
        end
    endtask

    task automatic test_lifo();
        logic [31:0] e;
        cyc(1'b1, 1'b0, 32'h0000_0100);
        cyc(1'b1, 1'b0, 32'h0000_0200);
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 1'b1, 32'h0);
            e = exp_q.pop_front();
            total++;
            if (bus.pc_valid !== 1'b1 || bus.pc_out !== e) begin
                bad++;
                $display("FAIL lifo_pop%0d got=%h/%b exp=%h/1", k, bus.pc_out, bus.pc_valid, e);
            end
        end
        total++;
        if (bus.ctx_empty !== 1'b1 || bus.ctx_err !== merr) begin
            bad++;
            $display("FAIL lifo_empty got=e%b r%b exp=e1 r%b", bus.ctx_empty, bus.ctx_err, merr);
        end
        cyc(1'b0, 1'b0, 32'h0);
        total++;
        if (bus.pc_valid !== 1'b0 || bus.pc_out !== 32'h100) begin
            bad++;
            $display("FAIL lifo_idle got=%h/%b exp=100/0", bus.pc_out, bus.pc_valid);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] e;
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 1'b0, 32'h1000 + 32'(i));
            total++;
            if (bus.ctx_full !== (i >= 4) || bus.ctx_err !== merr || bus.pc_valid !== 1'b0) begin
                bad++;
                $display("FAIL ovf_push%0d got=f%b r%b v%b exp=f%b r%b v0",
                         i, bus.ctx_full, bus.ctx_err, bus.pc_valid, (i >= 4), merr);
            end
        end
        total++;
        if (bus.ctx_err !== 1'b1) begin
            bad++;
            $display("FAIL ovf_err got=%b exp=1", bus.ctx_err);
        end
        cyc(1'b0, 1'b1, 32'h0);
        e = exp_q.pop_front();
        total++;
        if (bus.pc_out !== e || e !== 32'h1004 || bus.pc_valid !== 1'b1) begin
            bad++;
            $display("FAIL ovf_pop got=%h/%b exp=%h/1", bus.pc_out, bus.pc_valid, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        apply_reset();
        cyc(1'b1, 1'b0, 32'h11);
        cyc(1'b1, 1'b0, 32'h22);
        cyc(1'b1, 1'b1, 32'h33);
        e = exp_q.pop_front();
        total++;
        if (bus.pc_out !== e || bus.pc_valid !== 1'b1 || bus.ctx_empty !== 1'b0) begin
            bad++;
            $display("FAIL swap got=%h/%b e%b exp=%h/1 e0",
                     bus.pc_out, bus.pc_valid, bus.ctx_empty, e);
        end
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 1'b1, 32'h0);
            e = exp_q.pop_front();
            total++;
            if (bus.pc_out !== e || bus.pc_valid !== 1'b1) begin
                bad++;
                $display("FAIL swap_pop%0d got=%h/%b exp=%h/1", k, bus.pc_out, bus.pc_valid, e);
            end
        end
        total++;
        if (bus.ctx_empty !== 1'b1 || bus.ctx_err !== 1'b0) begin
            bad++;
            $display("FAIL swap_end got=e%b r%b exp=e1 r0", bus.ctx_empty, bus.ctx_err);
        end
    endtask

    task automatic test_underflow();
        logic [31:0] e;
        cyc(1'b0, 1'b1, 32'h0);
        total++;
        if (bus.pc_valid !== 1'b0 || bus.ctx_err !== merr || bus.pc_out !== 32'h11) begin
            bad++;
            $display("FAIL udf got=%h/%b r%b exp=11/0 r%b",
                     bus.pc_out, bus.pc_valid, bus.ctx_err, merr);
        end
        cyc(1'b1, 1'b1, 32'hA5A5);
        e = exp_q.pop_front();
        total++;
        if (bus.pc_out !== e || bus.pc_valid !== 1'b1 || bus.ctx_empty !== 1'b1) begin
            bad++;
            $display("FAIL passthru got=%h/%b e%b exp=%h/1 e1",
                     bus.pc_out, bus.pc_valid, bus.ctx_empty, e);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] e;
        cyc(1'b1, 1'b0, 32'h51);
        cyc(1'b1, 1'b0, 32'h52);
        bus.ctx_push = 1'b1;
        bus.pc_in    = 32'h53;
        bus.raddr1   = 3'd3;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (bus.ctx_empty !== 1'b1 || bus.ctx_full !== 1'b0 ||
            bus.pc_out !== 32'h0 || bus.ctx_err !== 1'b0) begin
            bad++;
            $display("FAIL arst_now got=e%b f%b pc=%h r%b exp=e1 f0 pc=0 r0",
                     bus.ctx_empty, bus.ctx_full, bus.pc_out, bus.ctx_err);
        end
        total++;
        if (bus.rdata1 !== 16'h0) begin
            bad++;
            $display("FAIL arst_regs got=%h exp=0", bus.rdata1);
        end
        @(posedge clk);
        #1;
        bus.ctx_push = 1'b0;
        rst = 1'b1;
        mstk.delete();
        exp_q.delete();
        merr = 1'b0;
        total++;
        if (bus.ctx_empty !== 1'b1 || bus.pc_valid !== 1'b0) begin
            bad++;
            $display("FAIL arst_hold got=e%b v%b exp=e1 v0", bus.ctx_empty, bus.pc_valid);
        end
        cyc(1'b1, 1'b0, 32'h99);
        cyc(1'b0, 1'b1, 32'h0);
        e = exp_q.pop_front();
        total++;
        if (bus.pc_out !== e || bus.pc_valid !== 1'b1 || bus.ctx_empty !== 1'b1) begin
            bad++;
            $display("FAIL arst_after got=%h/%b exp=%h/1", bus.pc_out, bus.pc_valid, e);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        merr  = 1'b0;
        rst   = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_lifo();
        test_overflow();
        test_back_to_back();
        test_underflow();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_ctx.md
Name: regfile_ctx

Overview:
- Next-generation register file for the pipelined core, parametrised in data width, register count and read-port addressing.
- Replaces the fixed private PC register pair with a hardware PC context stack of configurable depth, for nested interrupt/call save and restore.
- Sits between the decode stage (reads) and the write-back stage (writes, PC push/pop).

Parameters:
- DATA_W, 16, width of each general-purpose register.
- NUM_REGS, 8, number of general-purpose registers (power of 2, ≥2).
- PC_W, 32, width of a saved PC context.
- CTX_DEPTH, 4, number of PC contexts the stack holds (≥1).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- we  in  1  general register write enable.
- waddr  in  $clog2(NUM_REGS)  write address.
- wdata  in  DATA_W  write data.
- raddr1  in  $clog2(NUM_REGS)  read port 1 address.
- raddr2  in  $clog2(NUM_REGS)  read port 2 address.
- rdata1  out  DATA_W  read port 1 data (combinational).
- rdata2  out  DATA_W  read port 2 data (combinational).
- ctx_push  in  1  push pc_in onto the context stack.
- ctx_pop  in  1  pop the top context to pc_out.
- pc_in  in  PC_W  PC value to save.
- pc_out  out  PC_W  restored PC, registered.
- pc_valid  out  1  one-cycle pulse: pc_out holds a freshly popped value.
- ctx_full  out  1  stack holds CTX_DEPTH entries.
- ctx_empty  out  1  stack holds 0 entries.
- ctx_err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (rst=0, asynchronous): all registers 0, stack count 0, pc_out 0, pc_valid 0, ctx_full 0, ctx_empty 1, ctx_err 0. Deassertion takes effect at the next rising clk.
- Writes: when we=1, regs[waddr] <= wdata on the rising edge. Latency 1.
- Reads: rdata1/2 = regs[raddr1/2] combinationally. Same-cycle write behaviour is governed by the optional feature.
- Context stack is a LIFO with a count register 0..CTX_DEPTH. Flags are derived combinationally from the count.
- Push only, count<CTX_DEPTH: mem[count] <= pc_in; count+1.
- Pop only, count>0: pc_out <= mem[count-1]; pc_valid <= 1 for one cycle; count-1.
- Push+pop, count>0: swap. pc_out <= top, top <= pc_in, pc_valid <= 1, count unchanged.
- Push+pop, count=0: pass-through. pc_out <= pc_in, pc_valid <= 1, count stays 0, no error.
- Push when full (push only): ignored, ctx_err <= 1, stack contents unchanged.
- Pop when empty (pop only): pc_valid stays 0, pc_out holds its last value, ctx_err <= 1.
- ctx_err is cleared only by reset.
- pc_valid is 0 in every cycle without a successful pop.
- Reset mid-operation: any in-flight push or pop is discarded, and the stack is empty after reset.
- State encoding of the stack controller: EMPTY (count=0), PARTIAL, FULL (count=CTX_DEPTH). Transitions are driven only by the push/pop rules above.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If we=1 and raddrN==waddr, rdataN = wdata in the same cycle.
- Undefined: rdataN returns the pre-write register value, and the new value is visible the cycle after the write.

Decomposition:
- Package regfile_pkg holds:
  - localparams REG_AW = $clog2(NUM_REGS) and CTX_CW = $clog2(CTX_DEPTH+1);
  - the context-state enum {CTX_EMPTY, CTX_PARTIAL, CTX_FULL}.
- Sub-module pc_ctx_stack contains the LIFO memory, count, pc_out/pc_valid/flag/error logic.
- The top module contains the register array, read muxes and bypass.

Test Plan:
- Reset, then write regs[3]=16'hBEEF, read raddr1=3 next cycle -> rdata1=16'hBEEF; all other regs read 0.
- Write regs[5]=16'h1234 with raddr2=5 in the same cycle:
  - REGFILE_BYPASS_EN defined -> rdata2=16'h1234 in that cycle;
  - undefined -> rdata2=0 in that cycle, 16'h1234 the next cycle.
- Push 32'h0000_0100, 32'h0000_0200, then pop twice -> pc_out=32'h200 then 32'h100, pc_valid pulses each cycle, ctx_empty=1 at the end.
- Push 5 values with CTX_DEPTH=4 -> ctx_full=1 after the 4th push, ctx_err=1 after the 5th, and a later pop returns the 4th value.
- Pop on an empty stack -> pc_valid=0, ctx_err=1. Push+pop on an empty stack with pc_in=32'hA5A5 -> pc_out=32'hA5A5, pc_valid=1, count stays 0.
- Assert rst low asynchronously mid-push with count=2 -> count=0, ctx_empty=1, pc_out=0, ctx_err=0 immediately, without waiting for clk.
